// File: rtl/simplez_io_pkg.sv
// Shared constants and types for the simplez memory-mapped I/O responder.
package simplez_io_pkg;

    // CPU word addresses decoded by the responder
    localparam logic [8:0] ADDR_LEDS   = 9'd507;
    localparam logic [8:0] ADDR_TXSTAT = 9'd508;
    localparam logic [8:0] ADDR_TXDATA = 9'd509;

    // Default clock cycles per UART bit (115200 baud at 12 MHz)
    localparam int unsigned DEF_BAUD_DIV = 32'd104;

    // UART transmitter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Status word returned by a read of the transmitter status address
    function automatic logic [11:0] status_word(input logic ready);
        return {11'b0, ready};
    endfunction

endpackage

// File: rtl/simplez_io_if.sv
// CPU-side bus bundle shared by the CPU (master) and its peripherals (slave).
interface simplez_io_if;
    logic [8:0]  bus_addr;
    logic [11:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [11:0] bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata
    );
endinterface

// File: rtl/simplez_baudgen.sv
// Bit-period counter for the UART: counts 0..BAUD_DIV-1 and pulses tick
// during the last cycle of each bit period. clear realigns the phase to 0.
module simplez_baudgen
    import simplez_io_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] CNT_MAX = 16'(BAUD_DIV - 32'd1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        tick_q;
    logic        tick_d;

    // Next count: restart on clear, wrap at the end of a bit period
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = 16'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        tick_d = (cnt_d == CNT_MAX);
    end

    // Counter and registered tick flops
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/simplez_io.sv
// simplez memory-mapped I/O responder: LED register, transmitter status
// readback and an 8N1 UART transmitter fed by CPU stores.
module simplez_io
    import simplez_io_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic         clk,
    input  logic         rstn,
    simplez_io_if.slave  bus,
    output logic [3:0]   dataled,
    output logic         tx
);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic [3:0]  led_q, led_d;
    logic [11:0] rdata_q, rdata_d;

    logic        ready_s;
    logic        tx_wr_s;
    logic        baud_clr_s;
    logic        tick_s;

    assign ready_s = (state_q == ST_IDLE);
    assign tx_wr_s = bus.bus_we && (bus.bus_addr == ADDR_TXDATA);

    simplez_baudgen #(.BAUD_DIV(BAUD_DIV)) u_baudgen (
        .clk   (clk),
        .rstn  (rstn),
        .clear (baud_clr_s),
        .tick  (tick_s)
    );

    // Bus decode: LED register update and registered read data
    always_comb begin
        led_d   = led_q;
        rdata_d = rdata_q;
        if (bus.bus_we && (bus.bus_addr == ADDR_LEDS)) begin
            led_d = bus.bus_wdata[3:0];
        end else begin
            led_d = led_q;
        end
        // A write (alone or together with a read) always returns zero data
        if (bus.bus_we) begin
            rdata_d = 12'd0;
        end else if (bus.bus_re) begin
            if (bus.bus_addr == ADDR_TXSTAT) begin
                rdata_d = status_word(ready_s);
            end else begin
                rdata_d = 12'd0;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Transmitter FSM: next state, shift register, bit counter and tx level
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        baud_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_wr_s) begin
                    shift_d    = bus.bus_wdata[7:0];
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    baud_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            led_q   <= 4'd0;
            rdata_q <= 12'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            led_q   <= led_d;
            rdata_q <= rdata_d;
        end
    end

    assign dataled       = led_q;
    assign tx            = tx_q;
    assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_simplez_io.sv
// Bench for simplez_io: directed table, UART frame corner cases and random
// bus traffic, all checked against a cycle-indexed model of the UART frame.
module tb_simplez_io;
    import simplez_io_pkg::*;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] dataled;
    logic       tx;

    simplez_io_if bus_if();

    simplez_io #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus_if),
        .dataled (dataled),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;

    // Reference model: a frame is just "byte b accepted at edge m_start";
    // tx and ready after any edge t follow from arithmetic on t - m_start.
    bit          m_active = 1'b0;
    longint      m_start  = 0;
    logic [7:0]  m_byte   = 8'd0;
    logic [3:0]  m_led    = 4'd0;
    logic [11:0] m_rdata  = 12'd0;

    function automatic bit m_ready(longint t);
        return !m_active || (t >= m_start + 10 * B);
    endfunction

    function automatic logic m_tx(longint t);
        longint j;
        if (!m_active || t >= m_start + 10 * B) return 1'b1;
        j = (t - m_start) / B;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return m_byte[int'(j - 1)];
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one bus cycle, advance the model, then compare after the edge
    task automatic step(bit r, bit we, bit re, logic [8:0] a, logic [11:0] d);
        bit rdy_prev;
        rstn             = r;
        bus_if.bus_we    = we;
        bus_if.bus_re    = re;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        @(posedge clk);
        cyc++;
        rdy_prev = m_ready(cyc - 1);
        if (!r) begin
            m_active = 1'b0;
            m_led    = 4'd0;
            m_rdata  = 12'd0;
        end else begin
            if (we && a == ADDR_LEDS) m_led = d[3:0];
            if (we && a == ADDR_TXDATA && rdy_prev) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_byte   = d[7:0];
            end
            if (we) m_rdata = 12'd0;
            else if (re) m_rdata = (a == ADDR_TXSTAT) ? {11'b0, rdy_prev} : 12'd0;
        end
        #1;
        n_vec++;
        check("tx", {11'b0, tx}, {11'b0, m_tx(cyc)});
        check("dataled", {8'b0, dataled}, {8'b0, m_led});
        if (re || !r) check("rdata", bus_if.bus_rdata, m_rdata);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 9'd0, 12'd0);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100 && !m_ready(cyc); k++) step(1'b1, 1'b0, 1'b1, ADDR_TXSTAT, 12'd0);
        if (!m_ready(cyc)) begin
            n_err++;
            $display("FAIL wait_ready: model still busy at cycle %0d", cyc);
        end
    endtask

    typedef struct {
        bit          r;
        bit          we;
        bit          re;
        logic [8:0]  addr;
        logic [11:0] wdata;
        logic [11:0] exp_rdata;
        logic [3:0]  exp_led;
        logic        exp_tx;
    } vec_t;

    vec_t tbl[8];
    bit   pat[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic seq[40];
    int   cnt_tx_low;

    initial begin
        rstn = 1'b0;
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
        bus_if.bus_addr = 9'd0;
        bus_if.bus_wdata = 12'd0;

        // Directed table: reset, status, LED writes, unmapped reads
        tbl[0] = '{1'b0, 1'b0, 1'b0, 9'd0,   12'h000, 12'h000, 4'h0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 9'd0,   12'h000, 12'h000, 4'h0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 9'd508, 12'h000, 12'h001, 4'h0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 9'd507, 12'hFA5, 12'h000, 4'h5, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 9'd507, 12'h000, 12'h000, 4'h5, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 9'd508, 12'h000, 12'h001, 4'h5, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 9'd507, 12'h123, 12'h000, 4'h3, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 9'd100, 12'h000, 12'h000, 4'h3, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
            check($sformatf("tbl%0d_tx", i), {11'b0, tx}, {11'b0, tbl[i].exp_tx});
            check($sformatf("tbl%0d_led", i), {8'b0, dataled}, {8'b0, tbl[i].exp_led});
            if (tbl[i].re || !tbl[i].r)
                check($sformatf("tbl%0d_rdata", i), bus_if.bus_rdata, tbl[i].exp_rdata);
        end

        // Frame 0xA5 with status polled throughout
        step(1'b1, 1'b1, 1'b0, ADDR_TXDATA, 12'h0A5);
        seq[0] = tx;
        for (int i = 1; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b1, ADDR_TXSTAT, 12'd0);
            seq[i] = tx;
            check("frame_busy", bus_if.bus_rdata, 12'h000);
        end
        for (int i = 0; i < 40; i++)
            check($sformatf("frame_bit%0d", i), {11'b0, seq[i]}, {11'b0, pat[i / B]});
        step(1'b1, 1'b0, 1'b1, ADDR_TXSTAT, 12'd0);
        check("tx_after_stop", {11'b0, tx}, 12'h001);
        step(1'b1, 1'b0, 1'b1, ADDR_TXSTAT, 12'd0);
        check("status_after_frame", bus_if.bus_rdata, 12'h001);

        // Busy drop, then back-to-back acceptance at the first ready edge
        step(1'b1, 1'b1, 1'b0, ADDR_TXDATA, 12'h041);
        idle(10);
        step(1'b1, 1'b1, 1'b0, ADDR_TXDATA, 12'h042);
        check("drop_keeps_byte", {4'b0, m_byte}, 12'h041);
        wait_ready();
        step(1'b1, 1'b1, 1'b0, ADDR_TXDATA, 12'h042);
        check("b2b_start", {11'b0, tx}, 12'h000);
        idle(2 * B);

        // Reset during data bit 3, then nothing continues after release
        wait_ready();
        step(1'b1, 1'b1, 1'b0, ADDR_TXDATA, 12'h0F0);
        idle(4 * B + 1);
        step(1'b0, 1'b0, 1'b0, 9'd0, 12'd0);
        check("reset_tx_high", {11'b0, tx}, 12'h001);
        step(1'b1, 1'b0, 1'b1, ADDR_TXSTAT, 12'd0);
        check("reset_status", bus_if.bus_rdata, 12'h001);
        cnt_tx_low = 0;
        for (int i = 0; i < 12 * B; i++) begin
            step(1'b1, 1'b0, 1'b0, 9'd0, 12'd0);
            if (tx !== 1'b1) cnt_tx_low++;
        end
        check("no_continuation", 12'(cnt_tx_low), 12'd0);

        // Simultaneous write/read: frame starts and read data is zero
        step(1'b1, 1'b0, 1'b1, ADDR_TXSTAT, 12'd0);
        step(1'b1, 1'b1, 1'b1, ADDR_TXDATA, 12'h033);
        check("wr_rd_rdata", bus_if.bus_rdata, 12'h000);
        check("wr_rd_tx", {11'b0, tx}, 12'h000);
        wait_ready();

        // Random bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] a;
            case ($urandom_range(0, 3))
                0: a = ADDR_LEDS;
                1: a = ADDR_TXSTAT;
                2: a = ADDR_TXDATA;
                default: a = 9'($urandom);
            endcase
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), a, 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
